// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared defaults for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  localparam int XLEN_DEF     = 32;  // datapath width
  localparam int RADDR_W_DEF  = 5;   // register address width
  localparam int HZ_DEPTH_DEF = 3;   // tracked stages after ID (EX..WB)
  localparam int CNT_W_DEF    = 32;  // perf counter width

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Decode / stage-result / control bundle of the hazard
//                controller. master = pipeline side, slave = controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 32
);

  // Decode fields
  logic                  id_valid_i;
  logic [RADDR_W-1:0]    id_rs1_addr_i;
  logic [RADDR_W-1:0]    id_rs2_addr_i;
  logic                  id_rs1_used_i;
  logic                  id_rs2_used_i;
  logic [RADDR_W-1:0]    id_rd_addr_i;
  logic                  id_rd_we_i;
  // Per-stage result buses and execute outcome
  logic [DEPTH*XLEN-1:0] stage_data_i;
  logic [DEPTH-1:0]      stage_dvld_i;
  logic                  br_taken_i;
  // Control and bypass back to the pipeline
  logic                  stall_o;
  logic                  flush_o;
  logic                  fwd1_en_o;
  logic [XLEN-1:0]       fwd1_data_o;
  logic                  fwd2_en_o;
  logic [XLEN-1:0]       fwd2_data_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_rd_we_i, stage_data_i, stage_dvld_i, br_taken_i,
    input  stall_o, flush_o, fwd1_en_o, fwd1_data_o, fwd2_en_o, fwd2_data_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_addr_i, id_rd_we_i, stage_data_i, stage_dvld_i, br_taken_i,
    output stall_o, flush_o, fwd1_en_o, fwd1_data_o, fwd2_en_o, fwd2_data_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_scoreboard
//  Description : DEPTH-entry shift register of {vld, rd} for in-flight
//                register writes; flat per-entry match vectors for two
//                source addresses. Entry 0 = EX, entry DEPTH-1 = WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int DEPTH   = HZ_DEPTH_DEF
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  input  wire logic               load_vld_i,
  input  wire logic [RADDR_W-1:0] load_rd_i,
  input  wire logic [RADDR_W-1:0] rs1_addr_i,
  input  wire logic [RADDR_W-1:0] rs2_addr_i,
  output logic      [DEPTH-1:0]   rs1_match_o,
  output logic      [DEPTH-1:0]   rs2_match_o
);

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [RADDR_W-1:0] rd_q [DEPTH];
  logic [RADDR_W-1:0] rd_d [DEPTH];

  // Downstream stages never stall: advance every entry each cycle, new one at EX
  always_comb begin
    vld_d    = '0;
    vld_d[0] = load_vld_i;
    rd_d[0]  = load_vld_i ? load_rd_i : '0;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
  end

  // Entry storage, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end

  // x0 is hard-wired zero and never matches
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_match
      assign rs1_match_o[k] = vld_q[k] && (rd_q[k] == rs1_addr_i) && (rs1_addr_i != '0);
      assign rs2_match_o[k] = vld_q[k] && (rd_q[k] == rs2_addr_i) && (rs2_addr_i != '0);
    end
  endgenerate

endmodule : pipe_scoreboard
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline hazard control: tracks in-flight register writes,
//                drives stall/flush for PC/IF/ID and the ID operand bypass.
//                Build option PIPE_HAZARD_FWD_EN enables result bypass from
//                stages whose result is final; otherwise every match stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int DEPTH   = HZ_DEPTH_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input wire logic          clk_i,
  input wire logic          rst_i,
  pipe_hazard_ctrl_if.slave hz
);

  logic [DEPTH-1:0] w_sb_rs1_match, w_sb_rs2_match;
  logic [DEPTH-1:0] w_rs1_match, w_rs2_match;
  logic             w_rs1_hit, w_rs2_hit;
  logic             w_rs1_haz, w_rs2_haz;
  logic             w_stall, w_flush, w_load_vld;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A stalled or flushed ID instruction becomes a bubble; x0 writes are dropped
  assign w_load_vld = hz.id_valid_i && hz.id_rd_we_i && (hz.id_rd_addr_i != '0)
                      && !w_stall && !w_flush;

  pipe_scoreboard #(
    .RADDR_W (RADDR_W),
    .DEPTH   (DEPTH)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_vld_i  (w_load_vld),
    .load_rd_i   (hz.id_rd_addr_i),
    .rs1_addr_i  (hz.id_rs1_addr_i),
    .rs2_addr_i  (hz.id_rs2_addr_i),
    .rs1_match_o (w_sb_rs1_match),
    .rs2_match_o (w_sb_rs2_match)
  );

  // Only sources actually read by a real ID instruction count
  assign w_rs1_match = w_sb_rs1_match & {DEPTH{hz.id_valid_i & hz.id_rs1_used_i}};
  assign w_rs2_match = w_sb_rs2_match & {DEPTH{hz.id_valid_i & hz.id_rs2_used_i}};
  assign w_rs1_hit   = |w_rs1_match;
  assign w_rs2_hit   = |w_rs2_match;

`ifdef PIPE_HAZARD_FWD_EN
  logic            w_rs1_dvld, w_rs2_dvld;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;

  // Youngest producer wins: scan oldest to youngest so the lowest index sticks
  always_comb begin
    w_rs1_dvld = 1'b0;
    w_rs2_dvld = 1'b0;
    w_rs1_data = '0;
    w_rs2_data = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (w_rs1_match[k]) begin
        w_rs1_dvld = hz.stage_dvld_i[k];
        w_rs1_data = hz.stage_data_i[k*XLEN +: XLEN];
      end
      if (w_rs2_match[k]) begin
        w_rs2_dvld = hz.stage_dvld_i[k];
        w_rs2_data = hz.stage_data_i[k*XLEN +: XLEN];
      end
    end
  end

  // Final results bypass; a not-yet-final youngest producer (load-use) stalls
  assign w_rs1_haz      = w_rs1_hit && !w_rs1_dvld;
  assign w_rs2_haz      = w_rs2_hit && !w_rs2_dvld;
  assign hz.fwd1_en_o   = w_rs1_hit && w_rs1_dvld;
  assign hz.fwd2_en_o   = w_rs2_hit && w_rs2_dvld;
  assign hz.fwd1_data_o = hz.fwd1_en_o ? w_rs1_data : '0;
  assign hz.fwd2_data_o = hz.fwd2_en_o ? w_rs2_data : '0;
`else
  // Without bypass the result buses are not needed; any match waits for retire
  logic w_unused_stage;
  assign w_unused_stage = ^{hz.stage_data_i, hz.stage_dvld_i};
  assign w_rs1_haz      = w_rs1_hit;
  assign w_rs2_haz      = w_rs2_hit;
  assign hz.fwd1_en_o   = 1'b0;
  assign hz.fwd2_en_o   = 1'b0;
  assign hz.fwd1_data_o = '0;
  assign hz.fwd2_data_o = '0;
`endif

  // A taken branch kills IF/ID, so it overrides any stall
  assign w_flush    = hz.br_taken_i;
  assign w_stall    = (w_rs1_haz || w_rs2_haz) && !w_flush;
  assign hz.stall_o = w_stall;
  assign hz.flush_o = w_flush;

  // Saturating event counters: hold once all ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (w_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter state, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl
//                (DEPTH=3, CNT_W=4); expectations follow PIPE_HAZARD_FWD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int DEPTH   = 3;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic we);
    bus.id_valid_i    = v;
    bus.id_rs1_addr_i = rs1;
    bus.id_rs2_addr_i = rs2;
    bus.id_rs1_used_i = u1;
    bus.id_rs2_used_i = u2;
    bus.id_rd_addr_i  = rd;
    bus.id_rd_we_i    = we;
  endtask

  task automatic set_stage(input logic [2:0] dv, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2);
    bus.stage_dvld_i = dv;
    bus.stage_data_i = {d2, d1, d0};
  endtask

  task automatic drain();
    id_drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_stage(3'b000, 32'h0, 32'h0, 32'h0);
    repeat (4) step();
  endtask

  initial begin
    bus.br_taken_i = 1'b0;
    id_drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    set_stage(3'b000, 32'h0, 32'h0, 32'h0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall",     bus.stall_o,     1'b0);
    check("rst_flush",     bus.flush_o,     1'b0);
    check("rst_fwd1_en",   bus.fwd1_en_o,   1'b0);
    check("rst_fwd1_data", bus.fwd1_data_o, 32'h0);
    check("rst_stall_cnt", bus.stall_cnt_o, 4'h0);
    check("rst_flush_cnt", bus.flush_cnt_o, 4'h0);
    rst = 1'b0;
    step();

    // ---- 1: async reset in the middle of a stall ----
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    step();
    id_drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1);
    @(negedge clk);
    check("t1_stall_pre", bus.stall_o, 1'b1);
    step();
    @(negedge clk);
    check("t1_stall_mid", bus.stall_o, 1'b1);
    check("t1_cnt_mid",   bus.stall_cnt_o, 4'h1);
    #2 rst = 1'b1;
    #1;
    check("t1_stall_rst", bus.stall_o, 1'b0);
    check("t1_cnt_rst",   bus.stall_cnt_o, 4'h0);
    check("t1_fwd1_rst",  bus.fwd1_en_o, 1'b0);
    id_drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    rst = 1'b0;
    step();

    // ---- 2: back-to-back ALU dependency ----
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    step();
    id_drv(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1);
    set_stage(3'b111, 32'h0000_1234, 32'h0, 32'h0);
`ifdef PIPE_HAZARD_FWD_EN
    @(negedge clk);
    check("t2_fwd1_en",   bus.fwd1_en_o,   1'b1);
    check("t2_fwd1_data", bus.fwd1_data_o, 32'h0000_1234);
    check("t2_stall",     bus.stall_o,     1'b0);
    check("t2_cnt",       bus.stall_cnt_o, 4'h0);
    step();
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_on", bus.stall_o, 1'b1);
      step();
    end
    @(negedge clk);
    check("t2_stall_off", bus.stall_o,     1'b0);
    check("t2_cnt",       bus.stall_cnt_o, 4'h3);
    check("t2_fwd1_en",   bus.fwd1_en_o,   1'b0);
    step();
`endif
    drain();

    // ---- 3: load-use on rs2 ----
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
    step();
    id_drv(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0);
    set_stage(3'b110, 32'h0, 32'h5555_7777, 32'h0);
    @(negedge clk);
    check("t3_stall_ld",  bus.stall_o,   1'b1);
    check("t3_fwd2_ld",   bus.fwd2_en_o, 1'b0);
    step();
    @(negedge clk);
`ifdef PIPE_HAZARD_FWD_EN
    check("t3_stall_mem", bus.stall_o,     1'b0);
    check("t3_fwd2_en",   bus.fwd2_en_o,   1'b1);
    check("t3_fwd2_data", bus.fwd2_data_o, 32'h5555_7777);
`else
    check("t3_stall_mem", bus.stall_o,   1'b1);
    check("t3_fwd2_en",   bus.fwd2_en_o, 1'b0);
`endif
    drain();

    // ---- 4: taken branch beats a pending stall ----
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1);
    step();
    id_drv(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1);
    bus.br_taken_i = 1'b1;
    @(negedge clk);
    check("t4_flush", bus.flush_o, 1'b1);
    check("t4_stall", bus.stall_o, 1'b0);
    step();
    bus.br_taken_i = 1'b0;
    id_drv(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("t4_flush_cnt",  bus.flush_cnt_o, 4'h1);
    check("t4_bubble",     bus.stall_o,     1'b0);
    check("t4_flush_low",  bus.flush_o,     1'b0);
    drain();

    // ---- 5: x0 ignored, youngest producer wins, WB still covered ----
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    step();
    id_drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    check("t5_x0_stall", bus.stall_o,   1'b0);
    check("t5_x0_fwd",   bus.fwd1_en_o, 1'b0);
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1);
    step();
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
    step();
    id_drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1);
    step();
    id_drv(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0);
    set_stage(3'b111, 32'h0000_00AA, 32'h0000_0011, 32'h0000_00BB);
    @(negedge clk);
`ifdef PIPE_HAZARD_FWD_EN
    check("t5_prio_d1", bus.fwd1_data_o, 32'h0000_00AA);
    check("t5_prio_d2", bus.fwd2_data_o, 32'h0000_00AA);
    check("t5_prio_st", bus.stall_o,     1'b0);
`else
    check("t5_prio_st", bus.stall_o,     1'b1);
    check("t5_prio_d1", bus.fwd1_data_o, 32'h0);
`endif
    id_drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    id_drv(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
`ifdef PIPE_HAZARD_FWD_EN
    check("t5_wb_en",   bus.fwd1_en_o,   1'b1);
    check("t5_wb_data", bus.fwd1_data_o, 32'h0000_00BB);
    check("t5_wb_st",   bus.stall_o,     1'b0);
`else
    check("t5_wb_st",   bus.stall_o,     1'b1);
`endif
    drain();

    // ---- 6: stall counter saturation ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_cnt_clr",   bus.stall_cnt_o, 4'h0);
    check("t6_flush_clr", bus.flush_cnt_o, 4'h0);
    id_drv(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1);
    set_stage(3'b000, 32'h0, 32'h0, 32'h0);
    repeat (30) step();
    @(negedge clk);
    check("t6_cnt_sat",  bus.stall_cnt_o, 4'hF);
    repeat (8) step();
    @(negedge clk);
    check("t6_cnt_hold", bus.stall_cnt_o, 4'hF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
